mips_regfile_mp: RTL and testbench

//  Parametrised multi-port register file for the pipelined MIPS core.
//  NUM_RD synchronous-address read ports and two write ports (A: WB stage, B: secondary/late unit).

---
 rtl/mips_regfile_mp.sv | 92 +++++++++
 tb/tb_mips_regfile_mp.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mips_regfile_mp.sv
// rtl/mips_regfile_mp.sv - multi-port MIPS register file with registered read addresses and write bypass
module mips_regfile_mp #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 32,
    parameter int NUM_RD    = 2,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG0 = 1,
    parameter int AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rd_en,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wa_en,
    input  logic [AW-1:0]            wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [AW-1:0]            wb_addr,
    input  logic [DATA_W-1:0]        wb_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [AW-1:0]     cap_addr [NUM_RD];

    // Port B wins a same-address collision; register 0 is left untouched when hardwired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (!(ZERO_REG0 != 0 && r == 0)) begin
                    if (wb_en && wb_addr == AW'(r)) begin
                        regs[r] <= wb_data;
                    end else if (wa_en && wa_addr == AW'(r)) begin
                        regs[r] <= wa_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RD; i++) begin
                cap_addr[i] <= '0;
            end
        end else if (rd_en) begin
            for (int i = 0; i < NUM_RD; i++) begin
                cap_addr[i] <= rd_addr[i*AW +: AW];
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [DATA_W-1:0] arr_val;
        logic              in_range;
        logic [DATA_W-1:0] word;

        // The lookup only matches existing registers, so out-of-range addresses fall out as zero.
        always_comb begin
            arr_val  = '0;
            in_range = 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (cap_addr[i] == AW'(r)) begin
                    arr_val  = regs[r];
                    in_range = 1'b1;
                end
            end
        end

        always_comb begin
            word = '0;
            if (!rst_n || !in_range) begin
                word = '0;
            end else if (ZERO_REG0 != 0 && cap_addr[i] == '0) begin
                word = '0;
            end else if (BYPASS != 0 && wb_en && wb_addr == cap_addr[i]) begin
                word = wb_data;
            end else if (BYPASS != 0 && wa_en && wa_addr == cap_addr[i]) begin
                word = wa_data;
            end else begin
                word = arr_val;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = word;
    end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// tb/tb_mips_regfile_mp.sv - directed bench for mips_regfile_mp (default build and a no-bypass/no-zero/24-reg build)
module tb_mips_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en;
    logic [AW-1:0] ra0, ra1;
    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data, rd_data_alt;
    logic          wa_en, wb_en;
    logic [AW-1:0] wa_addr, wb_addr;
    logic [DW-1:0] wa_data, wb_data;

    int n_vec = 0;
    int n_err = 0;

    assign rd_addr = {ra1, ra0};

    always #5 clk = ~clk;

    mips_regfile_mp u_dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    mips_regfile_mp #(.NUM_REGS(24), .BYPASS(0), .ZERO_REG0(0)) u_alt (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_alt),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wa_en = 1'b1; wa_addr = a; wa_data = d;
    endtask

    task automatic idle_w();
        wa_en = 1'b0; wb_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rd_en = 1'b0; ra0 = '0; ra1 = '0;
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        tick();
        wr_a(5'd5, 32'hBAD0_BAD0);
        tick();
        #1;
        check("reset_rd0", rd_data[31:0], 32'h0);
        check("reset_rd1", rd_data[63:32], 32'h0);
        check("reset_alt_rd0", rd_data_alt[31:0], 32'h0);
        idle_w();
        rst_n = 1'b1;
        tick();

        // T1: write then read r5; the write held during reset must not have landed
        ra0 = 5'd5; rd_en = 1'b1;
        tick();
        check("no_write_in_reset", rd_data[31:0], 32'h0);
        wr_a(5'd5, 32'hDEADBEEF); rd_en = 1'b0;
        tick();
        idle_w(); ra0 = 5'd5; rd_en = 1'b1;
        tick();
        check("t1_rd0", rd_data[31:0], 32'hDEADBEEF);
        check("t1_alt_rd0", rd_data_alt[31:0], 32'hDEADBEEF);

        // T2: same-address collision, B wins
        wr_a(5'd7, 32'h11111111);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h22222222;
        tick();
        idle_w(); ra0 = 5'd7;
        tick();
        check("t2_collision", rd_data[31:0], 32'h22222222);
        check("t2_alt_collision", rd_data_alt[31:0], 32'h22222222);

        // T3: bypass vs no bypass on port 1
        ra1 = 5'd3;
        tick();
        rd_en = 1'b0;
        wr_a(5'd3, 32'h1234);
        #1;
        check("t3_bypass", rd_data[63:32], 32'h1234);
        check("t3_nobypass_pre", rd_data_alt[63:32], 32'h0);
        tick();
        idle_w();
        #1;
        check("t3_commit", rd_data[63:32], 32'h1234);
        check("t3_nobypass_post", rd_data_alt[63:32], 32'h1234);

        // T4: register 0
        ra0 = 5'd0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        wr_a(5'd0, 32'hFFFFFFFF);
        #1;
        check("t4_zero_bypass", rd_data[31:0], 32'h0);
        check("t4_alt_pre", rd_data_alt[31:0], 32'h0);
        tick();
        idle_w();
        #1;
        check("t4_zero_commit", rd_data[31:0], 32'h0);
        check("t4_alt_commit", rd_data_alt[31:0], 32'hFFFFFFFF);

        // T5: stall holds address 9 while rd_addr shows 10
        wr_a(5'd9, 32'h55);
        wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h66;
        ra0 = 5'd9; rd_en = 1'b1;
        tick();
        idle_w(); rd_en = 1'b0; ra0 = 5'd10;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_stall_hold", rd_data[31:0], 32'h55);
        end
        check("t5_alt_stall_hold", rd_data_alt[31:0], 32'h55);
        wr_a(5'd9, 32'hA5);
        #1;
        check("t5_stall_bypass", rd_data[31:0], 32'hA5);
        tick();
        idle_w();
        #1;
        check("t5_stall_commit", rd_data[31:0], 32'hA5);
        check("t5_alt_stall_commit", rd_data_alt[31:0], 32'hA5);

        // T6: fill, then reset mid-burst
        ra0 = 5'd1; ra1 = 5'd15; rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            wr_a(AW'(i), 32'(i));
            tick();
        end
        idle_w();
        #1;
        check("t6_fill_r1", rd_data[31:0], 32'd1);
        check("t6_fill_r15", rd_data[63:32], 32'd15);
        rst_n = 1'b0;
        #1;
        check("t6_rst_rd0", rd_data[31:0], 32'h0);
        check("t6_rst_alt_rd1", rd_data_alt[63:32], 32'h0);
        tick();
        rst_n = 1'b1;
        ra0 = 5'd9; ra1 = 5'd15;
        tick();
        check("t6_post_r9", rd_data[31:0], 32'h0);
        check("t6_post_r15", rd_data[63:32], 32'h0);

        // Out-of-range in the 24-register build
        wr_a(5'd30, 32'h30);
        wb_en = 1'b1; wb_addr = 5'd23; wb_data = 32'h23;
        tick();
        idle_w(); ra0 = 5'd30; ra1 = 5'd23;
        tick();
        check("oor_dut_r30", rd_data[31:0], 32'h30);
        check("oor_alt_r30", rd_data_alt[31:0], 32'h0);
        check("oor_alt_r23", rd_data_alt[63:32], 32'h23);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
